// File: rtl/x_pipeline_reg.sv
// X-stage pipeline data register: a DEPTH-deep chain of WIDTH-bit flops that
// cuts timing paths between datapath stages, with async active-low reset.
module x_pipeline_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] stage_p [DEPTH];

  // Stage boundaries: stage_p[0] captures in_data, each later stage shifts.
  // Reset is applied to the data words themselves so a reset mid-stream
  // discards every in-flight word and RESET_VAL drains out on release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_p[i] <= RESET_VAL;
      end
    end else begin
      stage_p[0] <= in_data;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_p[i] <= stage_p[i-1];
      end
    end
  end

  assign out_data = stage_p[DEPTH-1];

endmodule

// File: tb/tb_x_pipeline_reg.sv
// Bench for x_pipeline_reg: DEPTH=1 and DEPTH=3 instances driven in lockstep,
// a history-based reference model feeding expected queues, and a monitor.
module tb_x_pipeline_reg;

  localparam logic [31:0] RV1 = 32'h0000_0000;
  localparam logic [31:0] RV3 = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [31:0] out1;
  logic [31:0] out3;

  int errors = 0;
  int checks = 0;

  logic [31:0] hist [$];
  logic [31:0] exp1 [$];
  logic [31:0] exp3 [$];

  x_pipeline_reg #(.WIDTH(32), .DEPTH(1), .RESET_VAL(RV1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .out_data(out1)
  );

  x_pipeline_reg #(.WIDTH(32), .DEPTH(3), .RESET_VAL(RV3)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data), .out_data(out3)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Output after an edge is the word captured d edges ago since release,
  // otherwise the reset value.
  function automatic logic [31:0] ref_out(input int d, input logic [31:0] rv);
    if (hist.size() >= d) return hist[hist.size() - d];
    return rv;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      hist.delete();
      exp1.push_back(RV1);
      exp3.push_back(RV3);
    end else begin
      hist.push_back(in_data);
      exp1.push_back(ref_out(1, RV1));
      exp3.push_back(ref_out(3, RV3));
    end
  end

  always @(negedge rst) hist.delete();

  always @(negedge clk) begin
    if (exp1.size() > 0) check("out_d1", out1, exp1.pop_front());
    if (exp3.size() > 0) check("out_d3", out3, exp3.pop_front());
  end

  task automatic drive_word(input logic [31:0] d, input bit glitch);
    @(posedge clk);
    #2;
    if (glitch) in_data = $urandom;
    @(negedge clk);
    #2;
    in_data = d;
  endtask

  initial begin
    rst     = 1'b0;
    in_data = 32'h1234_5678;
    repeat (3) @(negedge clk);

    #2;
    rst     = 1'b1;
    in_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #2;
    in_data = 32'hCAFE_BABE;
    check("midcycle_hold_d1", out1, 32'hDEAD_BEEF);
    check("midcycle_hold_d3", out3, RV3);
    @(negedge clk);
    @(negedge clk);

    #2;
    rst = 1'b0;
    #1;
    check("async_rst_d1", out1, RV1);
    check("async_rst_d3", out3, RV3);

    @(negedge clk);
    #2;
    rst     = 1'b1;
    in_data = 32'h1;
    drive_word(32'h2, 1'b0);
    drive_word(32'h3, 1'b0);
    for (int i = 0; i < 40; i++) drive_word($urandom, 1'b1);

    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midstream_rst_d1", out1, RV1);
    check("midstream_rst_d3", out3, RV3);
    @(negedge clk);
    #2;
    rst     = 1'b1;
    in_data = $urandom;
    for (int i = 0; i < 6; i++) drive_word($urandom, 1'b1);

    repeat (2) @(negedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
